// File: rtl/adc_spi_sampler_pkg.sv
// adc_pkg: shared definitions for the SPI ADC sampler.
//  - state_t    : sampler FSM states
//  - DATA_W_DEF : default sample width
//  - frame_clks : clk cycles from a rate tick until the FSM is back in IDLE
//                 and can accept the next tick
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 8;

  // CS setup (clk_div) + frame_bits full sclk periods + DONE + return to IDLE
  function automatic int frame_clks(input int clk_div, input int frame_bits);
    return clk_div * (2 * frame_bits + 1) + 2;
  endfunction

endpackage

// File: rtl/adc_spi_sampler_timer.sv
// sample_rate_timer: free-running conversion-rate divider.
//  clk     in  system clock
//  reset   in  synchronous, active-high
//  enable  in  1 = count, 0 = hold counter at zero
//  tick    out 1-cycle strobe when the counter reaches SAMPLE_DIV-1
module sample_rate_timer #(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] count;

  // Rate counter: cleared while disabled so the first tick lands SAMPLE_DIV-1
  // cycles after enable rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = enable && (count == CNT_LAST);

endmodule

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: periodically reads one conversion from an 8-bit SPI
// (mode 3) ADC and presents it with a single-cycle valid strobe.
//  clk        in   system clock
//  reset      in   synchronous, active-high
//  enable     in   1 = run periodic sampling
//  adc_sdo    in   ADC serial data (changes after sclk falling edge)
//  adc_cs_n   out  ADC chip select, active low
//  adc_sclk   out  serial clock, idles high
//  sample     out  last completed conversion, MSB first
//  valid_out  out  1-cycle strobe: sample updated this cycle
//  busy       out  1 while a frame is in progress
module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 1000,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 3,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              adc_sdo,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] sample,
  output logic              valid_out,
  output logic              busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W:0]   DATA_FIRST = (BIT_W + 1)'(LEAD_BITS);
  localparam logic [BIT_W:0]   DATA_END   = (BIT_W + 1)'(LEAD_BITS + DATA_W);

  logic tick;

  sample_rate_timer #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  state_t            state, state_nx;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nx;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [DATA_W-1:0] sample_nx;
  logic              sclk_nx;
  logic              in_data;

  assign in_data = ({1'b0, bit_cnt} >= DATA_FIRST) && ({1'b0, bit_cnt} < DATA_END);

  // State and datapath registers; outputs are registered from next-state values
  // so cs_n/sclk/valid_out/busy line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      sample    <= '0;
      adc_sclk  <= 1'b1;
      adc_cs_n  <= 1'b1;
      valid_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      div_cnt   <= div_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      shreg     <= shreg_nx;
      sample    <= sample_nx;
      adc_sclk  <= sclk_nx;
      adc_cs_n  <= (state_nx == IDLE) || (state_nx == DONE);
      valid_out <= (state_nx == DONE);
      busy      <= (state_nx != IDLE);
    end
  end

  // Next-state logic. In SHIFT, adc_sclk itself is the phase bit: at the end of a
  // low phase sclk rises and sdo is captured; at the end of a high phase either
  // the next bit starts or the frame ends.
  always_comb begin
    state_nx   = state;
    div_cnt_nx = div_cnt;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    sample_nx  = sample;
    sclk_nx    = adc_sclk;
    case (state)
      IDLE: begin
        div_cnt_nx = '0;
        bit_cnt_nx = '0;
        sclk_nx    = 1'b1;
        if (tick) begin
          state_nx = CS_SETUP;
        end else begin
          state_nx = IDLE;
        end
      end
      CS_SETUP: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          sclk_nx    = 1'b0;
          state_nx   = SHIFT;
        end else begin
          div_cnt_nx = div_cnt + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          if (!adc_sclk) begin
            sclk_nx = 1'b1;
            if (in_data) begin
              shreg_nx = {shreg[DATA_W-2:0], adc_sdo};
            end else begin
              shreg_nx = shreg;
            end
          end else if (bit_cnt == BIT_LAST) begin
            // Data bits are all captured by now; publish on entry to DONE
            sclk_nx   = 1'b1;
            sample_nx = shreg;
            state_nx  = DONE;
          end else begin
            sclk_nx    = 1'b0;
            bit_cnt_nx = bit_cnt + BIT_W'(1);
          end
        end else begin
          div_cnt_nx = div_cnt + DIV_W'(1);
        end
      end
      DONE: begin
        sclk_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
